// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multi-cycle main controller: states, opcodes,
// funct codes, ALU operation selects, trap causes and the control bundle.
package mc_pkg;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC_R = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_EXEC_I = 4'd10,
    S_IWB    = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;

  localparam logic [1:0] TC_NONE = 2'b00;
  localparam logic [1:0] TC_OVF  = 2'b01;
  localparam logic [1:0] TC_ILL  = 2'b10;

  // Datapath controls that are pure functions of the state being entered.
  typedef struct packed {
    logic [2:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       trap;
  } ctrl_t;

  // Control values for a given state; anything not set stays 0.
  function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] op,
                                     input logic [2:0] r_alu);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.pc_en     = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.ext_op    = 1'b1;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.ext_op    = 1'b1;
      end
      S_MEMRD: c.iord = 1'b1;
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = r_alu;
      end
      S_RWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = ALU_SUB;
        c.pc_src      = 2'b01;
      end
      S_EXEC_I: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = 2'b10;
        c.alu_control = (op == OP_ORI) ? ALU_OR : ALU_ADD;
        c.ext_op      = (op != OP_ORI);
      end
      S_IWB:  c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_src = 2'b10;
        c.pc_en  = 1'b1;
      end
      S_TRAP: c.trap = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller <-> datapath bundle. There is no valid/ready handshake here:
// Op/Funct come from the IR and are stable from DECODE until the next FETCH,
// Zero/Overflow are same-cycle ALU flags, and every control output is a
// level that the datapath acts on in the cycle it is asserted.
interface mc_control_fsm_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       Overflow;
  logic [2:0] ALUControl;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ExtOp;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic       Trap;
  logic [1:0] TrapCause;
  logic [3:0] State;

  // Controller side.
  modport master (
    input  Op, Funct, Zero, Overflow,
    output ALUControl, ALUSrcA, ALUSrcB, ExtOp, IorD, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, PCSrc, PCEn, Trap, TrapCause, State
  );

  // Datapath side.
  modport slave (
    output Op, Funct, Zero, Overflow,
    input  ALUControl, ALUSrcA, ALUSrcB, ExtOp, IorD, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, PCSrc, PCEn, Trap, TrapCause, State
  );
endinterface

// File: rtl/mc_control_fsm_alu_decoder.sv
// Funct -> ALU operation for R-type instructions, with a legality flag and
// a flag marking the operations whose overflow is architecturally checked.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_control,
  output logic       o_valid,
  output logic       o_ovf_checked
);

  // Pure lookup; unknown funct defaults to ADD and is flagged invalid.
  always_comb begin
    o_alu_control = ALU_ADD;
    o_valid       = 1'b0;
    o_ovf_checked = 1'b0;
    case (i_funct)
      FN_ADD: begin
        o_valid       = 1'b1;
        o_ovf_checked = 1'b1;
      end
      FN_SUB: begin
        o_alu_control = ALU_SUB;
        o_valid       = 1'b1;
        o_ovf_checked = 1'b1;
      end
      FN_OR: begin
        o_alu_control = ALU_OR;
        o_valid       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle main controller: sequences fetch/decode/execute/memory/
// writeback, drives ALU select and datapath enables, diverts overflow and
// illegal instructions into a one-cycle TRAP that suppresses writeback.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter bit TRAP_ON_OVF     = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input logic            clk,
  input logic            reset,
  mc_control_fsm_if.master bus
);

  state_t     r_state;
  state_t     w_next;
  ctrl_t      r_out;
  logic [1:0] r_trap_cause;
  logic [1:0] w_cause;
  logic [2:0] w_alu_r;
  logic       w_funct_valid;
  logic       w_ovf_checked;
  state_t     w_illegal;

  mc_alu_decoder u_alu_dec (
    .i_funct      (bus.Funct),
    .o_alu_control(w_alu_r),
    .o_valid      (w_funct_valid),
    .o_ovf_checked(w_ovf_checked)
  );

  assign w_illegal = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;

  // Next-state selection and the cause recorded if that next state is TRAP.
  always_comb begin
    w_next  = S_FETCH;
    w_cause = TC_ILL;
    case (r_state)
      S_RST:   w_next = S_FETCH;
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW:    w_next = S_MEMADR;
          OP_RTYPE:        w_next = w_funct_valid ? S_EXEC_R : w_illegal;
          OP_BEQ:          w_next = S_BRANCH;
          OP_ADDI, OP_ORI: w_next = S_EXEC_I;
          OP_J:            w_next = S_JUMP;
          default:         w_next = w_illegal;
        endcase
      end
      S_MEMADR: w_next = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXEC_R: begin
        w_cause = TC_OVF;
        w_next  = (TRAP_ON_OVF && bus.Overflow && w_ovf_checked) ? S_TRAP : S_RWB;
      end
      S_EXEC_I: begin
        w_cause = TC_OVF;
        w_next  = (TRAP_ON_OVF && bus.Overflow && (bus.Op == OP_ADDI)) ? S_TRAP : S_IWB;
      end
      S_MEMWB, S_MEMWR, S_RWB, S_BRANCH, S_IWB, S_JUMP, S_TRAP: w_next = S_FETCH;
      default: w_next = S_FETCH;
    endcase
  end

  // State, registered Moore outputs for the state being entered, trap cause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_RST;
      r_out        <= '0;
      r_trap_cause <= TC_NONE;
    end else begin
      r_state <= w_next;
      r_out   <= ctrl_for(w_next, bus.Op, w_alu_r);
      if (w_next == S_TRAP) r_trap_cause <= w_cause;
    end
  end

  assign bus.ALUControl = r_out.alu_control;
  assign bus.ALUSrcA    = r_out.alu_src_a;
  assign bus.ALUSrcB    = r_out.alu_src_b;
  assign bus.ExtOp      = r_out.ext_op;
  assign bus.IorD       = r_out.iord;
  assign bus.MemWrite   = r_out.mem_write;
  assign bus.IRWrite    = r_out.ir_write;
  assign bus.RegDst     = r_out.reg_dst;
  assign bus.MemtoReg   = r_out.mem_to_reg;
  assign bus.RegWrite   = r_out.reg_write;
  assign bus.PCSrc      = r_out.pc_src;
  // Branch resolution is the one Mealy output: the PC loads when Zero is set.
  assign bus.PCEn       = r_out.pc_en | ((r_state == S_BRANCH) & bus.Zero);
  assign bus.Trap       = r_out.trap;
  assign bus.TrapCause  = r_trap_cause;
  assign bus.State      = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed scenarios plus a random instruction
// stream, each instruction checked against a per-instruction state trace and
// event counts derived from the instruction-level behaviour.
module tb_mc_control_fsm;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [3:0] exp_q[$];
  logic [1:0] model_cause;

  mc_control_fsm_if bus();

  mc_control_fsm #(.TRAP_ON_OVF(1'b1), .TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [22:0] all_outs();
    return {bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB, bus.ExtOp, bus.IorD,
            bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite,
            bus.PCSrc, bus.PCEn, bus.Trap, bus.TrapCause, bus.State};
  endfunction

  // Reference model: expected state trace (into exp_q) and event counts.
  task automatic model_instr(input logic [5:0] op, input logic [5:0] funct,
                             input logic zero, input logic ovf,
                             output int rw, output int mw, output int pe,
                             output int tr);
    exp_q = {};
    exp_q.push_back(S_FETCH);
    exp_q.push_back(S_DECODE);
    rw = 0; mw = 0; pe = 1; tr = 0;
    case (op)
      6'b100011: begin
        exp_q.push_back(S_MEMADR); exp_q.push_back(S_MEMRD); exp_q.push_back(S_MEMWB);
        rw = 1;
      end
      6'b101011: begin
        exp_q.push_back(S_MEMADR); exp_q.push_back(S_MEMWR);
        mw = 1;
      end
      6'b000000: begin
        if (funct == 6'b100000 || funct == 6'b100010) begin
          exp_q.push_back(S_EXEC_R);
          if (ovf) begin exp_q.push_back(S_TRAP); tr = 1; model_cause = 2'b01; end
          else begin exp_q.push_back(S_RWB); rw = 1; end
        end else if (funct == 6'b100101) begin
          exp_q.push_back(S_EXEC_R); exp_q.push_back(S_RWB); rw = 1;
        end else begin
          exp_q.push_back(S_TRAP); tr = 1; model_cause = 2'b10;
        end
      end
      6'b000100: begin exp_q.push_back(S_BRANCH); pe = pe + int'(zero); end
      6'b001000: begin
        exp_q.push_back(S_EXEC_I);
        if (ovf) begin exp_q.push_back(S_TRAP); tr = 1; model_cause = 2'b01; end
        else begin exp_q.push_back(S_IWB); rw = 1; end
      end
      6'b001101: begin exp_q.push_back(S_EXEC_I); exp_q.push_back(S_IWB); rw = 1; end
      6'b000010: begin exp_q.push_back(S_JUMP); pe = 2; end
      default: begin exp_q.push_back(S_TRAP); tr = 1; model_cause = 2'b10; end
    endcase
  endtask

  // Driver + checker for one instruction; starts and ends with FETCH sampled.
  task automatic run_instr(input string name, input logic [5:0] op,
                           input logic [5:0] funct, input logic zero,
                           input logic ovf);
    int rw, mw, pe, tr;
    int g_rw = 0, g_mw = 0, g_pe = 0, g_tr = 0, cyc = 0;
    logic [3:0] st;
    logic [3:0] exp_alu;
    bus.Op = op; bus.Funct = funct; bus.Zero = zero; bus.Overflow = ovf;
    model_instr(op, funct, zero, ovf, rw, mw, pe, tr);
    do begin
      st = bus.State;
      if (cyc < exp_q.size()) begin
        n_cmp++;
        if (st !== exp_q[cyc]) begin
          n_bad++;
          $display("FAIL %s state[%0d]: got %0d want %0d", name, cyc, st, exp_q[cyc]);
        end
      end
      g_rw += int'(bus.RegWrite); g_mw += int'(bus.MemWrite);
      g_pe += int'(bus.PCEn);     g_tr += int'(bus.Trap);
      if (st == S_MEMWB) begin
        n_cmp++;
        if ({bus.MemtoReg, bus.RegDst} !== 2'b10) begin
          n_bad++; $display("FAIL %s memwb_mux: got %b want 10", name, {bus.MemtoReg, bus.RegDst});
        end
      end
      if (st == S_BRANCH) begin
        n_cmp++;
        if ({bus.PCSrc, bus.PCEn, bus.ALUControl} !== {2'b01, zero, 3'b001}) begin
          n_bad++; $display("FAIL %s branch: got %b want %b", name,
                            {bus.PCSrc, bus.PCEn, bus.ALUControl}, {2'b01, zero, 3'b001});
        end
      end
      if (st == S_EXEC_R) begin
        exp_alu = (funct == 6'b100010) ? 4'b0001 : (funct == 6'b100101) ? 4'b0010 : 4'b0000;
        n_cmp++;
        if ({1'b0, bus.ALUControl} !== exp_alu) begin
          n_bad++; $display("FAIL %s exec_r_alu: got %b want %b", name, bus.ALUControl, exp_alu[2:0]);
        end
      end
      if (st == S_EXEC_I) begin
        exp_alu = (op == 6'b001101) ? 4'b0100 : 4'b0001;
        n_cmp++;
        if ({bus.ALUControl, bus.ExtOp} !== exp_alu) begin
          n_bad++; $display("FAIL %s exec_i_alu_ext: got %b want %b", name,
                            {bus.ALUControl, bus.ExtOp}, exp_alu);
        end
      end
      if (st == S_TRAP) begin
        n_cmp++;
        if ({bus.Trap, bus.TrapCause} !== {1'b1, model_cause}) begin
          n_bad++; $display("FAIL %s trap: got %b want %b", name,
                            {bus.Trap, bus.TrapCause}, {1'b1, model_cause});
        end
      end
      @(posedge clk); #1;
      cyc++;
    end while (bus.State != S_FETCH && cyc < 12);
    n_cmp++;
    if (cyc !== exp_q.size()) begin
      n_bad++; $display("FAIL %s cycles: got %0d want %0d", name, cyc, exp_q.size());
    end
    n_cmp++;
    if ({g_rw, g_mw, g_pe, g_tr} !== {rw, mw, pe, tr}) begin
      n_bad++; $display("FAIL %s counts rw/mw/pe/tr: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                        name, g_rw, g_mw, g_pe, g_tr, rw, mw, pe, tr);
    end
    n_cmp++;
    if (bus.TrapCause !== model_cause) begin
      n_bad++; $display("FAIL %s trap_cause_held: got %b want %b", name, bus.TrapCause, model_cause);
    end
  endtask

  task automatic check_after_reset(input string name);
    n_cmp++;
    if (all_outs() !== 23'd0) begin
      n_bad++; $display("FAIL %s outs_zero: got %h want 0", name, all_outs());
    end
    @(negedge clk); reset = 1'b0; #1;
    n_cmp++;
    if (bus.State !== 4'd0) begin
      n_bad++; $display("FAIL %s still_rst: got %0d want 0", name, bus.State);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.State, bus.IRWrite, bus.PCEn, bus.TrapCause} !== {4'd1, 1'b1, 1'b1, 2'b00}) begin
      n_bad++; $display("FAIL %s first_fetch: got %b want %b", name,
                        {bus.State, bus.IRWrite, bus.PCEn, bus.TrapCause}, {4'd1, 1'b1, 1'b1, 2'b00});
    end
    model_cause = 2'b00;
  endtask

  task automatic test_reset();
    bus.Op = 6'd0; bus.Funct = 6'd0; bus.Zero = 1'b1; bus.Overflow = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_after_reset("reset");
  endtask

  task automatic test_lw();
    run_instr("lw", 6'b100011, 6'h15, 1'b0, 1'b1);
  endtask

  task automatic test_sub_ovf();
    run_instr("sub_ovf", 6'b000000, 6'b100010, 1'b0, 1'b1);
    run_instr("add_no_ovf", 6'b000000, 6'b100000, 1'b1, 1'b0);
  endtask

  task automatic test_or_ovf();
    run_instr("or_ovf", 6'b000000, 6'b100101, 1'b0, 1'b1);
  endtask

  task automatic test_beq();
    run_instr("beq_taken", 6'b000100, 6'h00, 1'b1, 1'b0);
    run_instr("beq_not_taken", 6'b000100, 6'h00, 1'b0, 1'b1);
  endtask

  task automatic test_illegal_then_ori();
    run_instr("illegal_op", 6'b111111, 6'h3f, 1'b0, 1'b0);
    run_instr("ori_after_trap", 6'b001101, 6'h00, 1'b0, 1'b1);
    n_cmp++;
    if (bus.TrapCause !== 2'b10) begin
      n_bad++; $display("FAIL ori_keeps_cause: got %b want 10", bus.TrapCause);
    end
  endtask

  task automatic test_reset_mid_memwr();
    int k = 0;
    bus.Op = 6'b101011; bus.Funct = 6'h00; bus.Zero = 1'b1; bus.Overflow = 1'b0;
    while (bus.State != S_MEMWR && k < 8) begin
      @(posedge clk); #1; k++;
    end
    n_cmp++;
    if ({bus.State, bus.MemWrite} !== {4'd6, 1'b1}) begin
      n_bad++; $display("FAIL memwr_reached: got %b want %b", {bus.State, bus.MemWrite}, {4'd6, 1'b1});
    end
    #2 reset = 1'b1;
    #1;
    check_after_reset("mid_memwr_reset");
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[7];
    logic [5:0] fns[3];
    logic [5:0] op, fn;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b001101, 6'b000010};
    fns = '{6'b100000, 6'b100010, 6'b100101};
    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = $urandom_range(0, 8);
      op = (sel < 7) ? ops[sel] : 6'($urandom_range(0, 63));
      sel = $urandom_range(0, 3);
      fn = (sel < 3) ? fns[sel] : 6'($urandom_range(0, 63));
      run_instr("random", op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    model_cause = 2'b00;
    test_reset();
    test_lw();
    test_sub_ovf();
    test_or_ovf();
    test_beq();
    test_illegal_then_ori();
    test_reset_mid_memwr();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multi-cycle main controller that drives the ALU's 3-bit operation select and consumes its Zero and Overflow flags. It sequences fetch, decode, execute, memory and writeback for the MIPS-like subset the ALU supports (ADD/SUB/OR), generating the datapath enables and muxes. Overflow and illegal-opcode conditions divert to a one-cycle TRAP state that suppresses writeback.

Parameters:
TRAP_ON_OVF, 1, 1 = add/sub/addi overflow enters TRAP and blocks the write; 0 = overflow ignored.
TRAP_ON_ILLEGAL, 1, 1 = unknown Op/Funct enters TRAP; 0 = treated as NOP (DECODE->FETCH).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
Op  in  6  instruction[31:26], from IR; stable from DECODE until next FETCH
Funct  in  6  instruction[5:0], from IR
Zero  in  1  ALU zero flag, combinational, same cycle
Overflow  in  1  ALU overflow flag, combinational, same cycle
ALUControl  out  3  000 ADD, 001 SUB, 010 OR
ALUSrcA  out  1  0 PC, 1 register A
ALUSrcB  out  2  00 reg B, 01 const 4, 10 ext imm, 11 ext imm<<2
ExtOp  out  1  1 sign-extend, 0 zero-extend
IorD  out  1  memory address: 0 PC, 1 ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  IR load enable
RegDst  out  1  0 rt, 1 rd
MemtoReg  out  1  0 ALUOut, 1 MDR
RegWrite  out  1  register file write
PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
PCEn  out  1  PC write enable
Trap  out  1  one-cycle pulse in TRAP
TrapCause  out  2  01 overflow, 10 illegal; registered, held until next trap or reset
State  out  4  current state, for debug

Behaviour:
- Reset (async, active-high): state <= S_RST, TrapCause <= 00. All outputs are 0 while in S_RST. S_RST -> FETCH on the first clock after reset is deasserted.
- Outputs are Moore (decoded from state). Exception: PCEn in BRANCH = Zero.
- Unlisted outputs are 0 in each state.
- FETCH: IRWrite=1, ALUSrcB=01, ALUControl=ADD, PCSrc=00, PCEn=1. Always -> DECODE.
- DECODE: ALUSrcB=11, ExtOp=1, ADD (computes branch target into ALUOut). Next state by Op:
  - 100011 lw, 101011 sw -> MEMADR
  - 000000 R-type -> EXEC_R, if Funct is 100000 add, 100010 sub or 100101 or
  - 000100 beq -> BRANCH
  - 001000 addi, 001101 ori -> EXEC_I
  - 000010 j -> JUMP
  - anything else -> TRAP (cause 10)
- MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ADD. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1 -> MEMWB.
- MEMWB: MemtoReg=1, RegWrite=1 -> FETCH.
- MEMWR: IorD=1, MemWrite=1 -> FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct.
  - If Overflow=1 and Funct is add/sub (and TRAP_ON_OVF) -> TRAP (cause 01); else -> RWB.
  - OR never traps.
- RWB: RegDst=1, RegWrite=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01, PCEn=Zero -> FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10.
  - addi: ADD with ExtOp=1. Overflow=1 (and TRAP_ON_OVF) -> TRAP (cause 01).
  - ori: OR with ExtOp=0, never traps.
  - Otherwise -> IWB.
- IWB: RegWrite=1, RegDst=0 -> FETCH.
- JUMP: PCSrc=10, PCEn=1 -> FETCH.
- TRAP: Trap=1 and TrapCause updated on entry; RegWrite, MemWrite and PCEn stay 0 -> FETCH.
- Overflow and Zero are sampled only in EXEC_R, EXEC_I and BRANCH; they are don't-care elsewhere.
- Cycle counts: lw 5, sw 4, R 4, addi/ori 4, beq 3, j 3, trap 4 (FETCH, DECODE, EXEC, TRAP).
- Unreachable state encodings go to FETCH on the next edge.

Decomposition:
- Shared package mc_pkg holds:
  - 4-bit state encodings: S_RST 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC_R 7, RWB 8, BRANCH 9, EXEC_I 10, IWB 11, JUMP 12, TRAP 13.
  - Opcode and Funct constants.
  - ALUControl codes (ADD 000, SUB 001, OR 010).
  - TrapCause codes.
- One combinational sub-module, mc_alu_decoder: maps Funct to ALUControl plus a valid bit and an overflow-checked bit.

Test Plan:
- Reset asserted mid-MEMWR (MemWrite=1) -> all outputs 0 immediately (async). After deassert: S_RST for 1 cycle, then FETCH with IRWrite=1 and PCEn=1.
- Op=100011 (lw) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. Exactly one RegWrite=1 cycle with MemtoReg=1, RegDst=0.
- Op=0, Funct=100010 (sub), Overflow=1 in EXEC_R -> TRAP next cycle with Trap=1, TrapCause=01; RegWrite never 1. Then FETCH.
- Same stimulus with Funct=100101 (or) and Overflow=1 forced -> RWB, RegWrite=1, no trap.
- Op=000100 (beq): Zero=1 -> PCEn=1, PCSrc=01 in BRANCH. Zero=0 -> PCEn=0. Both cases take 3 cycles.
- Op=111111 -> DECODE -> TRAP with TrapCause=10. Then Op=001101 (ori) -> EXEC_I drives OR with ExtOp=0, then IWB; TrapCause still 10.
